// File: rtl/pe_filter_cache.sv
`default_nettype none
// ============================================================================
// Module      : pe_filter_cache
// Description : Double-banked filter-entry cache. The writer streams entries
//               into one bank while the reader fetches NUM_FILTERS entries
//               per address from the other, with a fixed 2-cycle read latency.
//               Optional macro PE_FILTER_CACHE_RD_CHECK_EN adds a sticky
//               read-protocol error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_filter_cache #(
  parameter int NUM_FILTERS  = 4,
  parameter int DOT_SIZE     = 8,
  parameter int FILTER_WIDTH = 8,
  parameter int EXP_WIDTH    = 5,
  parameter int DEPTH        = 16,
  localparam int c_entry_w   = DOT_SIZE*FILTER_WIDTH + EXP_WIDTH,
  localparam int c_addr_w    = $clog2(DEPTH),
  localparam int c_row_w     = NUM_FILTERS*c_entry_w
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic [c_entry_w-1:0] i_wr_data,
  output logic                 o_rd_bank_ready,
  input  logic                 i_rd_en,
  input  logic [c_addr_w-1:0]  i_rd_addr,
  input  logic                 i_rd_done,
  output logic                 o_rd_valid,
  output logic [c_row_w-1:0]   o_rd_data,
  output logic                 o_rd_error
);

  localparam int                c_fi_w    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam logic [c_addr_w-1:0] c_last_wa = c_addr_w'(DEPTH-1);
  localparam logic [c_fi_w-1:0]   c_last_fi = c_fi_w'(NUM_FILTERS-1);

  // One packed row per (bank, address); the bank bit is the address MSB.
  logic [c_row_w-1:0]  r_mem [2*DEPTH];

  logic [1:0]          r_full;
  logic                r_wb;
  logic                r_rb;
  logic [c_addr_w-1:0] r_wa;
  logic [c_fi_w-1:0]   r_fi;

  logic                r_rd_vld_s1;
  logic [c_row_w-1:0]  r_rd_data_s1;
  logic                r_rd_valid;
  logic [c_row_w-1:0]  r_rd_data;

  logic                w_wr_fire;
  logic                w_wr_last;
  logic                w_rd_accept;
  logic                w_rd_release;
  logic [1:0]          w_full_nxt;
  logic [c_row_w-1:0]  w_rd_row;

  assign w_wr_fire    = i_wr_valid && !r_full[r_wb];
  assign w_wr_last    = w_wr_fire && (r_wa == c_last_wa) && (r_fi == c_last_fi);
  assign w_rd_accept  = i_rd_en && r_full[r_rb];
  assign w_rd_release = i_rd_done && r_full[r_rb];
  assign w_rd_row     = r_mem[{r_rb, i_rd_addr}];

  // Completion and release always target different banks, so both may apply.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last)    w_full_nxt[r_wb] = 1'b1;
    if (w_rd_release) w_full_nxt[r_rb] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (w_wr_fire) begin
      r_mem[{r_wb, r_wa}][r_fi*c_entry_w +: c_entry_w] <= i_wr_data;
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_full <= '0;
      r_wb   <= 1'b0;
      r_rb   <= 1'b0;
      r_wa   <= '0;
      r_fi   <= '0;
    end else begin
      if (w_wr_fire) begin
        if (r_fi == c_last_fi) begin
          r_fi <= '0;
          r_wa <= (r_wa == c_last_wa) ? '0 : r_wa + 1'b1;
        end else begin
          r_fi <= r_fi + 1'b1;
        end
        if (w_wr_last) r_wb <= ~r_wb;
      end
      if (w_rd_release) r_rb <= ~r_rb;
      r_full <= w_full_nxt;
    end
  end

  // Row is captured at the request edge, so a later bank rewrite cannot alter it.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_rd_vld_s1  <= 1'b0;
      r_rd_data_s1 <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_rd_vld_s1 <= w_rd_accept;
      if (w_rd_accept) r_rd_data_s1 <= w_rd_row;
      r_rd_valid  <= r_rd_vld_s1;
      if (r_rd_vld_s1) r_rd_data <= r_rd_data_s1;
    end
  end

  assign o_wr_ready      = !r_full[r_wb];
  assign o_rd_bank_ready = r_full[r_rb];
  assign o_rd_valid      = r_rd_valid;
  assign o_rd_data       = r_rd_data;

`ifdef PE_FILTER_CACHE_RD_CHECK_EN
  logic r_rd_error;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_rd_error <= 1'b0;
    end else if ((i_rd_en || i_rd_done) && !r_full[r_rb]) begin
      r_rd_error <= 1'b1;
    end
  end

  assign o_rd_error = r_rd_error;
`else
  assign o_rd_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_filter_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_filter_cache
// Description : Self-checking bench for pe_filter_cache (NUM_FILTERS=2,
//               DEPTH=4) against a write-log reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_filter_cache;

  localparam int NF     = 2;
  localparam int DS     = 8;
  localparam int FW     = 8;
  localparam int XW     = 5;
  localparam int DEP    = 4;
  localparam int EW     = DS*FW + XW;
  localparam int AW     = 2;
  localparam int RDW    = NF*EW;
  localparam int BANK_N = NF*DEP;

  logic           clock = 1'b0;
  logic           i_reset = 1'b1;
  logic           i_wr_valid = 1'b0;
  logic           o_wr_ready;
  logic [EW-1:0]  i_wr_data = '0;
  logic           o_rd_bank_ready;
  logic           i_rd_en = 1'b0;
  logic [AW-1:0]  i_rd_addr = '0;
  logic           i_rd_done = 1'b0;
  logic           o_rd_valid;
  logic [RDW-1:0] o_rd_data;
  logic           o_rd_error;

  always #5 clock = ~clock;

  pe_filter_cache #(
    .NUM_FILTERS  (NF),
    .DOT_SIZE     (DS),
    .FILTER_WIDTH (FW),
    .EXP_WIDTH    (XW),
    .DEPTH        (DEP)
  ) dut (
    .clock           (clock),
    .i_reset         (i_reset),
    .i_wr_valid      (i_wr_valid),
    .o_wr_ready      (o_wr_ready),
    .i_wr_data       (i_wr_data),
    .o_rd_bank_ready (o_rd_bank_ready),
    .i_rd_en         (i_rd_en),
    .i_rd_addr       (i_rd_addr),
    .i_rd_done       (i_rd_done),
    .o_rd_valid      (o_rd_valid),
    .o_rd_data       (o_rd_data),
    .o_rd_error      (o_rd_error)
  );

  // Model: every accepted write in order since reset; bank k holds writes
  // k*BANK_N .. k*BANK_N+BANK_N-1, and reads always target bank 'released'.
  typedef struct {
    int             due;
    logic [RDW-1:0] data;
  } rd_t;

  logic [EW-1:0]  wlog[$];
  rd_t            pq[$];
  int             released;
  int             cyc;
  int             n_pass;
  int             n_total;
  logic           exp_err;
  logic [RDW-1:0] exp_last;

  function automatic int n_complete();
    return wlog.size() / BANK_N;
  endfunction

  function automatic logic [RDW-1:0] bank_row(input int bank, input int addr);
    logic [RDW-1:0] r;
    r = '0;
    for (int f = 0; f < NF; f++) r[f*EW +: EW] = wlog[bank*BANK_N + addr*NF + f];
    return r;
  endfunction

  task automatic check1(input string tag, input logic act, input logic exp);
    n_total++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, act, exp);
  endtask

  task automatic checkw(input string tag, input logic [RDW-1:0] act, input logic [RDW-1:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, act, exp);
  endtask

  task automatic model_clear();
    wlog.delete();
    pq.delete();
    released = 0;
    exp_err  = 1'b0;
    exp_last = '0;
  endtask

  // Entered at posedge+1; drives inputs, checks outputs, crosses one edge.
  task automatic step(input logic wv, input logic [EW-1:0] wd, input logic re,
                      input logic [AW-1:0] ra, input logic rd);
    logic exp_v;
    logic wr_ok;
    logic have_bank;
    logic err_set;
    i_wr_valid = wv;
    i_wr_data  = wd;
    i_rd_en    = re;
    i_rd_addr  = ra;
    i_rd_done  = rd;
    #1;
    have_bank = (n_complete() > released);
    wr_ok     = ((n_complete() - released) < 2);
    exp_v     = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      exp_v    = 1'b1;
      exp_last = pq[0].data;
      void'(pq.pop_front());
    end
    check1("wr_ready", o_wr_ready, wr_ok);
    check1("bank_ready", o_rd_bank_ready, have_bank);
    check1("rd_valid", o_rd_valid, exp_v);
    checkw("rd_data", o_rd_data, exp_last);
    check1("rd_error", o_rd_error, exp_err);
    if (re && have_bank) pq.push_back('{due: cyc + 2, data: bank_row(released, int'(ra))});
    err_set = 1'b0;
`ifdef PE_FILTER_CACHE_RD_CHECK_EN
    err_set = (re || rd) && !have_bank;
`endif
    @(posedge clock);
    #1;
    if (wv && wr_ok) wlog.push_back(wd);
    if (rd && have_bank) released++;
    if (err_set) exp_err = 1'b1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    i_reset    = 1'b1;
    i_wr_valid = 1'b0;
    i_rd_en    = 1'b0;
    i_rd_done  = 1'b0;
    #1;
    check1("rst_wr_ready", o_wr_ready, 1'b1);
    check1("rst_bank_ready", o_rd_bank_ready, 1'b0);
    check1("rst_rd_valid", o_rd_valid, 1'b0);
    checkw("rst_rd_data", o_rd_data, '0);
    check1("rst_rd_error", o_rd_error, 1'b0);
    model_clear();
    @(posedge clock);
    #1;
    i_reset = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    cyc     = 0;
    model_clear();
    do_reset();
    idle(1);

    // Fill bank 0 with 1..8, then read address 1.
    for (int v = 1; v <= 8; v++) step(1'b1, EW'(v), 1'b0, '0, 1'b0);
    idle(1);
    step(1'b0, '0, 1'b1, 2'd1, 1'b0);
    idle(1);
    check1("first_rd_valid", o_rd_valid, 1'b1);
    checkw("first_rd_data", o_rd_data, {EW'(4), EW'(3)});
    idle(1);

    // Back-to-back reads of every address.
    for (int a = 0; a < DEP; a++) step(1'b0, '0, 1'b1, AW'(a), 1'b0);
    idle(3);

    // Fill bank 1, then hold a 17th write against back-pressure.
    for (int v = 9; v <= 16; v++) step(1'b1, EW'(v), 1'b0, '0, 1'b0);
    check1("both_full_ready", o_wr_ready, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, EW'(17), 1'b0, '0, 1'b0);

    // Read addr 3 together with release; new writes must not disturb it.
    step(1'b1, EW'(17), 1'b1, 2'd3, 1'b1);
    step(1'b1, EW'(17), 1'b0, '0, 1'b0);
    check1("old_bank_valid", o_rd_valid, 1'b1);
    checkw("old_bank_data", o_rd_data, {EW'(8), EW'(7)});
    for (int v = 18; v <= 24; v++) step(1'b1, EW'(v), 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 2'd0, 1'b1);
    step(1'b0, '0, 1'b1, 2'd2, 1'b0);
    idle(3);

    // Read and release with no full bank.
    do_reset();
    step(1'b0, '0, 1'b1, 2'd0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    idle(3);
`ifdef PE_FILTER_CACHE_RD_CHECK_EN
    check1("empty_rd_error", o_rd_error, 1'b1);
`else
    check1("empty_rd_error", o_rd_error, 1'b0);
`endif

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, EW'({$urandom(), $urandom(), $urandom()}),
           $urandom_range(0, 1) == 1, AW'($urandom_range(0, DEP-1)),
           $urandom_range(0, 11) == 0);
    end
    idle(3);

    // Reset mid-fill and mid-read, then refill from address 0.
    do_reset();
    for (int v = 1; v <= 8; v++) step(1'b1, EW'(v + 100), 1'b0, '0, 1'b0);
    for (int v = 1; v <= 5; v++) step(1'b1, EW'(v + 150), 1'b1, AW'(v % DEP), 1'b0);
    do_reset();
    idle(2);
    for (int v = 201; v <= 208; v++) step(1'b1, EW'(v), 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 2'd0, 1'b0);
    idle(1);
    check1("post_rst_valid", o_rd_valid, 1'b1);
    checkw("post_rst_data", o_rd_data, {EW'(202), EW'(201)});
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
